// File: rtl/uart_boot_sequencer.sv
// UART boot sequencer: parses L/R/H host commands, writes program words
// to SoC memory over req/ack and gates the core reset.
module uart_boot_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter bit          HOLD_AT_RESET  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  output logic        core_reset,
  output logic        busy,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;
  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_LEN, S_DATA, S_WRITE, S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          txv_q, txv_d;
  logic [7:0]    txd_q, txd_d;
  logic          req_q, req_d;
  logic          core_q, core_d;
  logic          err_q, err_d;
  logic          ovr_q, ovr_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [15:0]   len_w;

  assign len_w = {rx_data, cnt_q[15:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      txv_q   <= 1'b0;
      txd_q   <= '0;
      req_q   <= 1'b0;
      core_q  <= HOLD_AT_RESET;
      err_q   <= 1'b0;
      ovr_q   <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      txv_q   <= txv_d;
      txd_q   <= txd_d;
      req_q   <= req_d;
      core_q  <= core_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    txv_d   = txv_q;
    txd_d   = txd_q;
    req_d   = req_q;
    core_d  = core_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            (rx_data == CMD_L): begin
              state_d = S_ADDR;
              err_d   = 1'b0;
              core_d  = 1'b1;
              bcnt_d  = '0;
              cnt_d   = '0;
              ovr_d   = 1'b0;
              tmr_d   = '0;
            end
            (rx_data == CMD_R): begin
              err_d   = 1'b0;
              core_d  = 1'b0;
              state_d = S_RESP;
              txv_d   = 1'b1;
              txd_d   = ACK;
            end
            (rx_data == CMD_H): begin
              err_d   = 1'b0;
              core_d  = 1'b1;
              state_d = S_RESP;
              txv_d   = 1'b1;
              txd_d   = ACK;
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_RESP;
              txv_d   = 1'b1;
              txd_d   = NAK;
            end
          endcase
        end
      end
      S_ADDR, S_LEN, S_DATA: begin
        if (!rx_valid) begin
          if (tmr_q == TMAX) begin
            err_d   = 1'b1;
            state_d = S_RESP;
            txv_d   = 1'b1;
            txd_d   = NAK;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end else begin
          tmr_d  = '0;
          bcnt_d = bcnt_q + 2'd1;
          unique case (1'b1)
            (state_q == S_ADDR): begin
              addr_d = {rx_data, addr_q[31:8]};
              if (bcnt_q == 2'd3) state_d = S_LEN;
            end
            (state_q == S_LEN): begin
              cnt_d = len_w;
              if (bcnt_q == 2'd1) begin
                bcnt_d = '0;
                if (len_w == 16'd0) begin
                  state_d = S_RESP;
                  txv_d   = 1'b1;
                  txd_d   = ACK;
                end else begin
                  state_d = S_DATA;
                end
              end
            end
            default: begin
              wdata_d = {rx_data, wdata_q[31:8]};
              if (bcnt_q == 2'd3) begin
                state_d = S_WRITE;
                req_d   = 1'b1;
              end
            end
          endcase
        end
      end
      S_WRITE: begin
        tmr_d = '0;
        if (rx_valid) begin
          err_d = 1'b1;
          ovr_d = 1'b1;
        end
        if (mem_ack && req_q) begin
          req_d  = 1'b0;
          addr_d = {addr_q[31:2] + 30'd1, 2'b00};
          cnt_d  = cnt_q - 16'd1;
          // An overrun abandons the rest of the frame after this word
          if (ovr_q || rx_valid) begin
            state_d = S_RESP;
            txv_d   = 1'b1;
            txd_d   = NAK;
          end else if (cnt_q == 16'd1) begin
            state_d = S_RESP;
            txv_d   = 1'b1;
            txd_d   = ACK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_RESP: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) begin
          txv_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_valid   = txv_q;
  assign tx_data    = txd_q;
  assign mem_req    = req_q;
  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign mem_wdata  = wdata_q;
  assign core_reset = core_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;

endmodule
